// File: rtl/comparators_pkg.sv
// Shared types for the comparator block: FSM state encoding and {l,g,e} result codes.
package comparators_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned magnitude compare; exactly one output is high.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       lt,
  output logic       gt,
  output logic       eq
);

  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Wide unsigned comparator that scans operand bit pairs MSB-first through one shared
// 2-bit slice, stopping at the first unequal pair.
module serial_mag_comparator
  import comparators_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int unsigned NPAIR  = WIDTH / 2;
  localparam int unsigned IdxW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NPAIR - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  logic [1:0] pair_a, pair_b;
  logic       pair_lt, pair_gt, pair_eq;

  // Pair select mux feeding the single shared slice.
  always_comb begin
    pair_a = '0;
    pair_b = '0;
    for (int unsigned k = 0; k < NPAIR; k++) begin
      if (idx_q == IdxW'(k)) begin
        pair_a = ra_q[2*k +: 2];
        pair_b = rb_q[2*k +: 2];
      end
    end
  end

  cmp2_slice u_slice (
    .a  (pair_a),
    .b  (pair_b),
    .lt (pair_lt),
    .gt (pair_gt),
    .eq (pair_eq)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IdxTop;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (pair_gt) begin
          res_d   = GT;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (pair_lt) begin
          res_d   = LT;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (pair_eq && (idx_q == '0)) begin
          res_d   = EQ;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign {l, g, e} = res_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator at WIDTH=8 and WIDTH=2.
module tb_serial_mag_comparator;
  import comparators_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, l8, g8, e8;
  logic       busy2, done2, l2, g2, e2;

  int checks   = 0;
  int failures = 0;
  bit sel2     = 1'b0;

  logic       o_busy, o_done;
  logic [2:0] o_res;
  assign o_busy = sel2 ? busy2 : busy8;
  assign o_done = sel2 ? done2 : done8;
  assign o_res  = sel2 ? {l2, g2, e2} : {l8, g8, e8};

  serial_mag_comparator #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .l     (l8),
    .g     (g8),
    .e     (e8)
  );

  serial_mag_comparator #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .l     (l2),
    .g     (g2),
    .e     (e2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] av, input logic [7:0] bv);
    if (sel2) begin
      start2 = s;
      a2     = av[1:0];
      b2     = bv[1:0];
    end else begin
      start8 = s;
      a8     = av;
      b8     = bv;
    end
  endtask

  // One compare: checks latency, busy duration, flags and single-cycle done.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] exp_res, input int exp_lat);
    int n;
    int bcnt;
    drive(1'b1, av, bv);
    @(negedge clk);
    drive(1'b0, ~av, ~bv);
    n    = 0;
    bcnt = 0;
    while (!o_done && n < 20) begin
      if (o_busy) bcnt++;
      @(negedge clk);
      n++;
    end
    check_eq({tag, " done"}, 32'(o_done), 32'd1);
    check_eq({tag, " latency"}, n, exp_lat);
    check_eq({tag, " busy cycles"}, bcnt, exp_lat);
    check_eq({tag, " flags"}, 32'(o_res), 32'(exp_res));
    check_eq({tag, " busy at done"}, 32'(o_busy), 32'd0);
    @(negedge clk);
    check_eq({tag, " done pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset w8", {29'd0, busy8, done8, l8 | g8 | e8}, 32'd0);
    check_eq("reset w2", {29'd0, busy2, done2, l2 | g2 | e2}, 32'd0);

    sel2 = 1'b0;
    run_cmp("w8 c3>43", 8'hC3, 8'h43, GT, 1);
    repeat (2) @(negedge clk);
    check_eq("w8 hold gt", 32'(o_res), 32'(GT));
    run_cmp("w8 5a==5a", 8'h5A, 8'h5A, EQ, 4);
    run_cmp("w8 12<13", 8'h12, 8'h13, LT, 4);
    run_cmp("w8 20>10", 8'h20, 8'h10, GT, 2);
    run_cmp("w8 34<38", 8'h34, 8'h38, LT, 3);

    // Start held through RUN; the second request is taken only in DONE.
    drive(1'b1, 8'h80, 8'h00);
    @(negedge clk);
    drive(1'b1, 8'h00, 8'hFF);
    @(negedge clk);
    check_eq("b2b first done", 32'(o_done), 32'd1);
    check_eq("b2b first flags", 32'(o_res), 32'(GT));
    check_eq("b2b first busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    check_eq("b2b reaccept done", 32'(o_done), 32'd0);
    check_eq("b2b reaccept busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check_eq("b2b second done", 32'(o_done), 32'd1);
    check_eq("b2b second flags", 32'(o_res), 32'(LT));
    @(negedge clk);
    check_eq("b2b second pulse", 32'(o_done), 32'd0);

    // Abort on the second RUN cycle.
    drive(1'b1, 8'h01, 8'h01);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("abort busy before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort outputs", {27'd0, busy8, done8, l8, g8, e8}, 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check_eq("abort no done", seen, 0);

    sel2 = 1'b1;
    run_cmp("w2 10==10", 8'h02, 8'h02, EQ, 1);
    run_cmp("w2 01<10", 8'h01, 8'h02, LT, 1);
    repeat (3) @(negedge clk);
    check_eq("w2 hold lt", 32'(o_res), 32'(LT));
    run_cmp("w2 11>01", 8'h03, 8'h01, GT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Multi-cycle magnitude comparator for WIDTH-bit unsigned operands, built around one shared 2-bit compare slice. It latches both operands on a start request and scans them two bits per cycle, MSB pair first, stopping at the first unequal pair. It returns less/greater/equal flags with a one-cycle done pulse. It sits in the comparators area as the sequencing controller that turns the 2-bit compare datapath into a wide comparator at minimal area.

## Interface
- WIDTH, default 8, operand width in bits; must be even and at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request a compare; accepted only when busy is low.
- a  input  WIDTH  operand A, unsigned; sampled only in the accept cycle.
- b  input  WIDTH  operand B, unsigned; sampled only in the accept cycle.
- busy  output  1  high while a compare is in progress (state RUN).
- done  output  1  one-cycle pulse when a result is written.
- l  output  1  result: A < B.
- g  output  1  result: A > B.
- e  output  1  result: A == B.

## Operation
- NPAIR = WIDTH/2. Pair k is bits [2k+1:2k]. The scan runs from pair NPAIR-1 down to pair 0.
- States:
  - IDLE: waiting for start.
  - RUN: comparing one pair per cycle.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE: if start=1, latch a into ra and b into rb, set idx=NPAIR-1, go to RUN.
  - RUN: compare the pair at idx of ra and rb.
    - Pair A > pair B: g=1, l=0, e=0, go to DONE.
    - Pair A < pair B: l=1, g=0, e=0, go to DONE.
    - Pairs equal and idx=0: e=1, l=0, g=0, go to DONE.
    - Pairs equal and idx>0: decrement idx, stay in RUN.
  - DONE: if start=1, accept a new compare (latch operands, go to RUN, idx=NPAIR-1); otherwise go to IDLE.
- Start while in RUN is ignored. No queuing, no error flag.
- l, g, e are written only on entry to DONE and hold until the next result. Exactly one of them is 1 after any completed compare.
- Operand inputs are don't-care outside the accept cycle. Changes during RUN have no effect.
- Width rules:
  - idx width is clog2(NPAIR), minimum 1 bit.
  - ra and rb are WIDTH bits wide.
  - No arithmetic beyond the idx decrement. idx never wraps below 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, l=0, g=0, e=0. ra, rb and idx are don't-care.
- Reset asserted mid-RUN or mid-DONE aborts the compare. All outputs return to their reset values on that same edge. No done pulse is produced for the aborted compare.
- Accept edge T0 (start=1 with busy=0). busy=1 from after T0.
- A decision at scan step j (j=1..NPAIR) is made on edge T0+j. After that edge, done=1, busy=0, and the flags are valid.
- Latency from start to done:
  - Best case (MSB pair differs): 1 cycle after accept.
  - Worst case (equal operands, or only pair 0 differs): NPAIR cycles after accept.
- done is high for exactly one cycle unless a back-to-back start is accepted in DONE. In that case done is still high for only that one cycle, and busy rises on the next edge.
- Maximum throughput is one compare per NPAIR+1 cycles in the worst case.

## Structure
- Shared package comparators_pkg holds:
  - the state enum IDLE/RUN/DONE;
  - the result encoding constants for {l,g,e}: LT=3'b100, GT=3'b010, EQ=3'b001.
- One sub-module, cmp2_slice: combinational 2-bit unsigned compare with outputs lt, gt, eq. It is instantiated once and fed by an idx-selected mux of ra and rb.
- Everything else (FSM, idx counter, operand registers, result registers) lives in the top module.

## Test plan
- WIDTH=8, a=8'hC3, b=8'h43, start for 1 cycle → pair 3 is 11 vs 01; g=1, l=0, e=0; done 1 cycle after accept; busy high for exactly 1 cycle.
- a=8'h5A, b=8'h5A → e=1, l=0, g=0; done 4 cycles after accept; busy high for 4 cycles.
- a=8'h12, b=8'h13 → pairs 3..1 equal, pair 0 is 10 vs 11; l=1; done 4 cycles after accept.
- Accept a=8'h80, b=8'h00, then hold start=1 with a=8'h00, b=8'hFF through RUN → the second request is ignored during RUN; g=1 after 1 cycle; the second request is accepted in DONE and returns l=1 one cycle later.
- Start a=8'h01, b=8'h01; pull rst_n=0 on the second RUN cycle → busy=0, done=0, l=g=e=0 after that edge; no done pulse afterwards.
- WIDTH=2: a=2'b10, b=2'b10 → e=1 with done 1 cycle after accept. Then a=2'b01, b=2'b10 → l=1. Flags hold their value across idle cycles.
